spi_master_mc: RTL
==================

SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the bits per transfer (minimum 2).
REQ-002 The block SHALL take parameter NCS, default 2, as the number of chip-select lines (minimum 1); CS_W = max(1, clog2(NCS)).
REQ-003 The block SHALL take parameter DIV_W, default 4, as the width of the SCLK divider input.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start_in  input  1  single-cycle transfer request.
REQ-007 cs_sel_in  input  CS_W  index of the chip-select to assert.
REQ-008 mode_in  input  2  {CPOL, CPHA} SPI mode.
REQ-009 div_in  input  DIV_W  half-period H = div_in+1 clk cycles.
REQ-010 tx_data_in  input  DATA_W  word to transmit, MSB first.
REQ-011 busy_out  output  1  transfer in progress.
REQ-012 done_out  output  1  one-cycle completion pulse.
REQ-013 rx_data_out  output  DATA_W  last received word.
REQ-014 sclk_out / mosi_out / miso_in  output/output/input  1 each  SPI bus.
REQ-015 cs_n_out  output  NCS  active-low chip selects, one-hot-low or all high.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, XFER, HOLD; busy_out SHALL be high in every state except IDLE.
REQ-017 start_in SHALL be accepted only in IDLE with cs_sel_in < NCS; otherwise it is ignored with no state or output change.
REQ-018 On acceptance, tx_data_in, mode_in, div_in and cs_sel_in SHALL be latched; later input changes SHALL not affect the transfer.
REQ-019 On the edge of acceptance the FSM SHALL enter SETUP, drive cs_n_out[cs_sel] low and place the tx MSB on mosi_out.
REQ-020 SETUP, each SCLK phase and HOLD SHALL each last exactly H clk cycles, timed by a DIV_W-bit down-counter.
REQ-021 sclk_out SHALL equal latched CPOL in IDLE, SETUP and HOLD, and toggle after every H cycles in XFER for exactly 2*DATA_W edges.
REQ-022 CPHA=0: miso_in SHALL be sampled on each leading edge and mosi_out advanced on each trailing edge except the last.
REQ-023 CPHA=1: mosi_out SHALL be advanced on each leading edge except the first and miso_in sampled on each trailing edge.
REQ-024 Received bits SHALL shift in MSB first into an internal register; rx_data_out SHALL update only on the done_out cycle.
REQ-025 After the final edge the FSM SHALL enter HOLD with cs still low; at HOLD end cs_n_out SHALL return all-high and FSM to IDLE.
REQ-026 busy_out SHALL be high for exactly (2*DATA_W+2)*H cycles starting the cycle after acceptance.
REQ-027 done_out SHALL be high for one cycle, the first IDLE cycle after a transfer; a start_in in that cycle SHALL be accepted (back-to-back).
REQ-028 mosi_out SHALL hold its last value in IDLE; at most one cs_n_out bit SHALL be low at any time.

Reset
REQ-029 On rst: FSM=IDLE, cs_n_out all 1, sclk_out=0, mosi_out=0, busy_out=0, done_out=0, rx_data_out=0, counters 0.
REQ-030 rst asserted mid-transfer SHALL abort within the same edge with no done_out pulse and rx_data_out unchanged from reset value.

Verification
REQ-031 DATA_W=8, mode 0, div 0, tx 0xA5, miso looped to mosi -> rx_data_out=0xA5, busy 18 cycles, 8 rising sclk edges, done once.
REQ-032 mode 3, div 2, tx 0x00, slave model drives 0x3C -> sclk idles high, rx_data_out=0x3C, busy 54 cycles.
REQ-033 NCS=3, cs_sel 3 with start -> ignored, cs_n_out=3'b111, busy stays 0; cs_sel 2 -> only cs_n_out[2] low.
REQ-034 start held high through two transfers, tx 0x11 then 0x22 -> second accepted on done cycle, two done pulses, mid-transfer starts ignored.
REQ-035 rst asserted at sclk edge 5 of a transfer -> next cycle all outputs at reset values, no done_out.

Source files
------------

// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_mc
// Description : Multi-chip-select SPI master, all four modes, runtime divider.
// Revision    : 1.0
// ============================================================================
module spi_master_mc #(
    parameter int DATA_W = 8,
    parameter int NCS    = 2,
    parameter int DIV_W  = 4,
    localparam int CS_W  = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [CS_W-1:0]   cs_sel_in,
    input  logic [1:0]        mode_in,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [DATA_W-1:0] tx_data_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              sclk_out,
    output logic              mosi_out,
    input  logic              miso_in,
    output logic [NCS-1:0]    cs_n_out
);

    localparam int                EDGE_W      = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] C_LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic [CS_W:0]     C_NCS       = (CS_W + 1)'(NCS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic                r_cpol;
    logic                r_cpha;
    logic [EDGE_W-1:0]   r_edge;
    logic                r_sclk;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_done;
    logic [NCS-1:0]      r_cs_n;

    logic                w_accept;
    logic                w_tick;
    logic                w_last_edge;
    logic                w_leading;
    logic [NCS-1:0]      w_cs_dec;

    assign w_accept    = (r_state == S_IDLE) && start_in && ({1'b0, cs_sel_in} < C_NCS);
    assign w_tick      = (r_cnt == '0);
    assign w_last_edge = (r_edge == C_LAST_EDGE);
    // Edges are numbered from 1, so an even count means the next edge is odd (leading).
    assign w_leading   = ~r_edge[0];

    always_comb begin
        w_cs_dec = '0;
        for (int i = 0; i < NCS; i++) begin
            if (cs_sel_in == CS_W'(i)) begin
                w_cs_dec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)               w_state_next = S_SETUP;
            S_SETUP: if (w_tick)                 w_state_next = S_XFER;
            S_XFER:  if (w_tick && w_last_edge)  w_state_next = S_HOLD;
            S_HOLD:  if (w_tick)                 w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_edge    <= '0;
            r_sclk    <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_cs_n    <= '1;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_cnt  <= div_in;
                    r_div  <= div_in;
                    r_cpol <= mode_in[1];
                    r_cpha <= mode_in[0];
                    r_sclk <= mode_in[1];
                    r_tx   <= tx_data_in;
                    r_edge <= '0;
                    r_cs_n <= ~w_cs_dec;
                end
            end else begin
                r_cnt <= w_tick ? r_div : r_cnt - 1'b1;
            end

            if (r_state == S_XFER && w_tick) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + 1'b1;
                // CPHA selects which edge samples and which edge shifts MOSI.
                if (w_leading) begin
                    if (!r_cpha) begin
                        r_rx <= {r_rx[DATA_W-2:0], miso_in};
                    end else if (r_edge != '0) begin
                        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    if (r_cpha) begin
                        r_rx <= {r_rx[DATA_W-2:0], miso_in};
                    end else if (!w_last_edge) begin
                        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
            end

            if (r_state == S_HOLD && w_tick) begin
                r_cs_n    <= '1;
                r_done    <= 1'b1;
                r_rx_data <= r_rx;
            end
        end
    end

    assign busy_out    = (r_state != S_IDLE);
    assign done_out    = r_done;
    assign rx_data_out = r_rx_data;
    assign sclk_out    = r_sclk;
    assign mosi_out    = r_tx[DATA_W-1];
    assign cs_n_out    = r_cs_n;

endmodule
`default_nettype wire
